// File: rtl/instruction_sequencer_pkg.sv
// Shared constants for the instruction sequencer and its external ALU:
// default widths, opcode encodings and the sequencer state enumeration.
package instruction_sequencer_pkg;

   localparam int unsigned OPCODE_WIDTH_DEF   = 4;
   localparam int unsigned REGISTER_WIDTH_DEF = 8;
   localparam int unsigned REG_ADDR_WIDTH_DEF = 3;
   localparam int unsigned PC_WIDTH_DEF       = 8;

   localparam int unsigned OP_NOP       = 0;
   localparam int unsigned OP_ADD       = 1;
   localparam int unsigned OP_INCREMENT = 2;
   localparam int unsigned OP_AND       = 3;
   localparam int unsigned OP_OR        = 4;
   localparam int unsigned OP_LOAD      = 5;
   localparam int unsigned OP_STORE     = 6;
   localparam int unsigned OP_JUMPZ     = 7;
   localparam int unsigned OP_HALT      = 15;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_HALTED
   } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Program-memory fetch and ALU signals of the sequencer; master is the
// sequencer side, slave is the memory/ALU side.
interface instruction_sequencer_if
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned OPCODE_WIDTH   = OPCODE_WIDTH_DEF,
   parameter int unsigned REGISTER_WIDTH = REGISTER_WIDTH_DEF,
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned PC_WIDTH       = PC_WIDTH_DEF
);

   logic [PC_WIDTH-1:0]                    instrAddr;
   logic                                   instrReq;
   logic [OPCODE_WIDTH+REG_ADDR_WIDTH-1:0] instrData;
   logic                                   instrValid;
   logic [OPCODE_WIDTH-1:0]                aluOpCode;
   logic [REGISTER_WIDTH-1:0]              aluRegisterValue;
   logic [REGISTER_WIDTH-1:0]              aluAccumulator;
   logic [REGISTER_WIDTH-1:0]              aluResult;

   modport master (
      output instrAddr, instrReq, aluOpCode, aluRegisterValue, aluAccumulator,
      input  instrData, instrValid, aluResult
   );

   modport slave (
      input  instrAddr, instrReq, aluOpCode, aluRegisterValue, aluAccumulator,
      output instrData, instrValid, aluResult
   );

endinterface

// File: rtl/instruction_sequencer_register_file.sv
// Register file: asynchronous read, synchronous write, synchronous clear.
module register_file #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// Three-cycle fetch/decode/execute sequencer driving an external ALU,
// with an accumulator, program counter and a small register file.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned OPCODE_WIDTH   = OPCODE_WIDTH_DEF,
   parameter int unsigned REGISTER_WIDTH = REGISTER_WIDTH_DEF,
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned PC_WIDTH       = PC_WIDTH_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   instruction_sequencer_if.master bus,
   output logic                    halted
);

   localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + REG_ADDR_WIDTH;

   seq_state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]       pc_q, pc_d;
   logic [REGISTER_WIDTH-1:0] acc_q, acc_d;
   logic [INSTR_WIDTH-1:0]    ir_q, ir_d;
   logic [REGISTER_WIDTH-1:0] reg_value_q, reg_value_d;
   logic [OPCODE_WIDTH-1:0]   alu_op_q, alu_op_d;
   logic                      instr_req_q, instr_req_d;
   logic                      halted_q, halted_d;

   logic [OPCODE_WIDTH-1:0]   ir_op;
   logic [REG_ADDR_WIDTH-1:0] ir_addr;
   logic                      rf_we;
   logic [REGISTER_WIDTH-1:0] rf_rd_data;

   assign ir_op   = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
   assign ir_addr = ir_q[REG_ADDR_WIDTH-1:0];

   register_file #(
      .WIDTH      (REGISTER_WIDTH),
      .ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_rf (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (rf_we),
      .wr_addr (ir_addr),
      .wr_data (acc_q),
      .rd_addr (ir_addr),
      .rd_data (rf_rd_data)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      ir_d        = ir_q;
      reg_value_d = reg_value_q;
      rf_we       = 1'b0;

      case (state_q)
         ST_FETCH: begin
            if (bus.instrValid) begin
               ir_d    = bus.instrData;
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            reg_value_d = rf_rd_data;
            state_d     = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            state_d = ST_FETCH;
            case (ir_op)
               OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_INCREMENT),
               OPCODE_WIDTH'(OP_AND), OPCODE_WIDTH'(OP_OR): acc_d = bus.aluResult;
               OPCODE_WIDTH'(OP_LOAD):  acc_d = reg_value_q;
               OPCODE_WIDTH'(OP_STORE): rf_we = 1'b1;
               OPCODE_WIDTH'(OP_JUMPZ): begin
                  if (acc_q == '0) begin
                     pc_d = PC_WIDTH'(reg_value_q);
                  end
               end
               OPCODE_WIDTH'(OP_HALT):  state_d = ST_HALTED;
               default: ;
            endcase
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_FETCH;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      instr_req_d = (state_d == ST_FETCH);
      halted_d    = (state_d == ST_HALTED);
      alu_op_d    = (state_d == ST_EXECUTE) ? ir_op : OPCODE_WIDTH'(OP_NOP);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_FETCH;
         pc_q        <= '0;
         acc_q       <= '0;
         ir_q        <= '0;
         reg_value_q <= '0;
         alu_op_q    <= OPCODE_WIDTH'(OP_NOP);
         instr_req_q <= 1'b1;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         ir_q        <= ir_d;
         reg_value_q <= reg_value_d;
         alu_op_q    <= alu_op_d;
         instr_req_q <= instr_req_d;
         halted_q    <= halted_d;
      end
   end

   // Masked by reset so a request/halt never shows while reset is held.
   assign bus.instrReq         = instr_req_q & ~reset;
   assign halted               = halted_q & ~reset;
   assign bus.aluOpCode        = reset ? OPCODE_WIDTH'(OP_NOP) : alu_op_q;
   assign bus.instrAddr        = pc_q;
   assign bus.aluRegisterValue = reg_value_q;
   assign bus.aluAccumulator   = acc_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: zero-wait and stalled fetch,
// wrap-around arithmetic, JUMPZ, unused opcodes, pc wrap and reset cases.
module tb_instruction_sequencer;

   localparam int unsigned OW = 4;
   localparam int unsigned RW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned PW = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic halted;
   logic mem_ready = 1'b1;
   logic [OW+AW-1:0] prog [256];
   logic [RW-1:0] alu_res;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;

   always #5 clock = ~clock;

   instruction_sequencer_if #(
      .OPCODE_WIDTH   (OW),
      .REGISTER_WIDTH (RW),
      .REG_ADDR_WIDTH (AW),
      .PC_WIDTH       (PW)
   ) bus ();

   instruction_sequencer #(
      .OPCODE_WIDTH   (OW),
      .REGISTER_WIDTH (RW),
      .REG_ADDR_WIDTH (AW),
      .PC_WIDTH       (PW)
   ) u_dut (
      .clock  (clock),
      .reset  (reset),
      .bus    (bus),
      .halted (halted)
   );

   // Zero-wait program memory (stallable) and a reference ALU.
   assign bus.instrData  = prog[bus.instrAddr];
   assign bus.instrValid = mem_ready;
   assign bus.aluResult  = alu_res;

   always_comb begin
      alu_res = '0;
      case (bus.aluOpCode)
         4'd1: alu_res = bus.aluAccumulator + bus.aluRegisterValue;
         4'd2: alu_res = bus.aluAccumulator + 8'd1;
         4'd3: alu_res = bus.aluAccumulator & bus.aluRegisterValue;
         4'd4: alu_res = bus.aluAccumulator | bus.aluRegisterValue;
         default: alu_res = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [OW+AW-1:0] ins(input int unsigned op, input int unsigned r);
      logic [3:0] o;
      logic [2:0] a;
      o = op[3:0];
      a = r[2:0];
      return {o, a};
   endfunction

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic run_to(input int unsigned target);
      while (cyc < target) tick();
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = '0;
   endtask

   // Leaves the bench at the sample point of cycle 0 (first FETCH).
   task automatic do_reset(input string tag);
      mem_ready = 1'b1;
      reset = 1'b1;
      #1;
      check({tag, "_rst_halted"}, 32'(halted), 32'd0);
      check({tag, "_rst_req"}, 32'(bus.instrReq), 32'd0);
      check({tag, "_rst_op"}, 32'(bus.aluOpCode), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      cyc = 0;
      check({tag, "_req"}, 32'(bus.instrReq), 32'd1);
      check({tag, "_addr"}, 32'(bus.instrAddr), 32'd0);
      check({tag, "_acc"}, 32'(bus.aluAccumulator), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Program A: LOAD r0; INCREMENT; STORE r1; HALT
      clear_prog();
      prog[0] = ins(5, 0);
      prog[1] = ins(2, 0);
      prog[2] = ins(6, 1);
      prog[3] = ins(15, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      do_reset("a");
      for (int k = 0; k <= 12; k++) begin
         check("a_req", 32'(bus.instrReq), (k % 3 == 0 && k < 12) ? 32'd1 : 32'd0);
         if (k % 3 == 0 && k < 12) check("a_addr", 32'(bus.instrAddr), 32'(k / 3));
         check("a_halted", 32'(halted), (k == 12) ? 32'd1 : 32'd0);
         if (k < 12) tick();
      end
      check("a_r1", 32'(u_dut.u_rf.regs_q[1]), 32'd1);
      check("a_acc", 32'(bus.aluAccumulator), 32'd1);
      run_to(16);
      check("a_stay_halted", 32'(halted), 32'd1);
      check("a_stay_req", 32'(bus.instrReq), 32'd0);
      check("a_stay_pc", 32'(bus.instrAddr), 32'd4);

      // Program B: build r2=0x0F and acc=0xF1, then ADD r2 wraps to 0.
      clear_prog();
      prog[0]  = ins(2, 0);  prog[1]  = ins(6, 7);  prog[2]  = ins(1, 7);
      prog[3]  = ins(2, 0);  prog[4]  = ins(6, 7);  prog[5]  = ins(1, 7);
      prog[6]  = ins(2, 0);  prog[7]  = ins(6, 7);  prog[8]  = ins(1, 7);
      prog[9]  = ins(2, 0);  prog[10] = ins(6, 2);  prog[11] = ins(6, 7);
      prog[12] = ins(1, 7);  prog[13] = ins(6, 7);  prog[14] = ins(1, 7);
      prog[15] = ins(6, 7);  prog[16] = ins(1, 7);  prog[17] = ins(6, 7);
      prog[18] = ins(1, 7);  prog[19] = ins(2, 0);  prog[20] = ins(1, 2);
      prog[21] = ins(15, 0);
      do_reset("halt");
      check("halt_r1_cleared", 32'(u_dut.u_rf.regs_q[1]), 32'd0);
      run_to(33);
      check("b_acc_0f", 32'(bus.aluAccumulator), 32'h0F);
      run_to(60);
      check("b_acc_f1", 32'(bus.aluAccumulator), 32'hF1);
      run_to(62);
      check("b_exec_op", 32'(bus.aluOpCode), 32'd1);
      check("b_exec_r2", 32'(bus.aluRegisterValue), 32'h0F);
      run_to(63);
      check("b_acc_wrap", 32'(bus.aluAccumulator), 32'h00);
      run_to(66);
      check("b_halted", 32'(halted), 32'd1);

      // Reset during EXECUTE of ADD r7 (acc 0x78 would become 0xF0).
      do_reset("b2");
      run_to(56);
      check("b2_exec_op", 32'(bus.aluOpCode), 32'd1);
      check("b2_exec_acc", 32'(bus.aluAccumulator), 32'h78);
      do_reset("exec");
      tick();
      check("exec_decode_req", 32'(bus.instrReq), 32'd0);
      check("exec_decode_pc", 32'(bus.instrAddr), 32'd1);

      // Program C: r3=0x20, JUMPZ taken with acc=0, not taken with acc=5.
      clear_prog();
      prog[0]  = ins(2, 0);
      for (int i = 1; i <= 9; i += 2) begin
         prog[i]     = ins(6, 7);
         prog[i + 1] = ins(1, 7);
      end
      prog[11] = ins(6, 3);
      prog[12] = ins(5, 0);
      prog[13] = ins(7, 3);
      for (int i = 8'h20; i <= 8'h24; i++) prog[i] = ins(2, 0);
      prog[8'h25] = ins(7, 3);
      prog[8'h26] = ins(15, 0);
      do_reset("c");
      run_to(41);
      check("c_jz_op", 32'(bus.aluOpCode), 32'd7);
      check("c_jz_acc", 32'(bus.aluAccumulator), 32'd0);
      check("c_jz_reg", 32'(bus.aluRegisterValue), 32'h20);
      run_to(42);
      check("c_taken_addr", 32'(bus.instrAddr), 32'h20);
      check("c_taken_req", 32'(bus.instrReq), 32'd1);
      run_to(57);
      check("c_acc5", 32'(bus.aluAccumulator), 32'd5);
      check("c_fetch_25", 32'(bus.instrAddr), 32'h25);
      run_to(60);
      check("c_not_taken", 32'(bus.instrAddr), 32'h26);

      // Program D: 4 wait states, unused opcode 9, then pc wrap via NOPs.
      clear_prog();
      prog[0] = ins(2, 0);
      prog[1] = ins(6, 4);
      prog[2] = ins(9, 4);
      do_reset("d");
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("d_wait_req", 32'(bus.instrReq), 32'd1);
         check("d_wait_addr", 32'(bus.instrAddr), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      check("d_accept_req", 32'(bus.instrReq), 32'd1);
      tick();
      check("d_decode_req", 32'(bus.instrReq), 32'd0);
      check("d_decode_pc", 32'(bus.instrAddr), 32'd1);
      run_to(12);
      check("d_op9", 32'(bus.aluOpCode), 32'd9);
      check("d_op9_reg", 32'(bus.aluRegisterValue), 32'd1);
      run_to(13);
      check("d_op9_pc", 32'(bus.instrAddr), 32'd3);
      check("d_op9_acc", 32'(bus.aluAccumulator), 32'd1);
      check("d_op9_r4", 32'(u_dut.u_rf.regs_q[4]), 32'd1);
      run_to(769);
      check("d_pc_ff", 32'(bus.instrAddr), 32'hFF);
      run_to(772);
      check("d_pc_wrap", 32'(bus.instrAddr), 32'd0);
      check("d_wrap_req", 32'(bus.instrReq), 32'd1);
      check("d_wrap_acc", 32'(bus.aluAccumulator), 32'd1);
      check("d_wrap_halted", 32'(halted), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
